// File: rtl/bt_uart_tx_pkg.sv
// Shared UART definitions: line state encoding and bit-period derivation,
// used by both the Bluetooth receiver and transmitter so their timing agrees.
package bt_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  localparam int DEFAULT_BIT_CYCLES = bit_cycles(50000000, 9600);

endpackage

// File: rtl/bt_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through output; the head entry
// is visible on dout so the transmitter can load it on the same edge it pops.
module bt_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr;
  logic             do_rd;

  // Full/empty come from the registered count, so a write is refused while
  // full even if a pop happens on the same edge.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter for the Bluetooth module TX line: queues bytes in a
// small FIFO and sends them LSB-first, back-to-back while data is queued.
module bt_uart_tx
  import bt_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    data_in,
  input  logic                          send,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BAUD_LAST  = 16'(BIT_CYCLES - 1);

  uart_state_t state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        baud_last;

  bt_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (send),
    .rd_en   (pop),
    .din     (data_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign baud_last = (baud_reg == BAUD_LAST);
  assign ready     = !fifo_full;
  assign tx        = tx_reg;
  assign busy      = busy_reg;
  assign tx_done   = (state_reg == STOP) && baud_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_last ? 16'd0 : baud_reg + 16'd1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          tx_next      = shift_reg[0];
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_idx_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_last) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// Directed bench for bt_uart_tx at BIT_CYCLES=10: captures line waveforms
// cycle by cycle and compares them with hand-built expected frames.
module tb_bt_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [1023:0] obs_tx, obs_busy, obs_done;
  logic [1023:0] exp_tx, exp_busy, exp_done;

  bt_uart_tx #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .send       (send),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Index i of a capture is the cycle after the (i+1)-th edge from capture start.
  task automatic capture(input int len);
    obs_tx = '1; obs_busy = '0; obs_done = '0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      obs_tx[i] = tx; obs_busy[i] = busy; obs_done[i] = tx_done;
    end
  endtask

  task automatic clear_expect();
    exp_tx = '1; exp_busy = '0; exp_done = '0;
  endtask

  task automatic add_frame(input logic [7:0] b, input int base);
    for (int i = 0; i < 100; i++) begin
      if (i < 10)      exp_tx[base+i] = 1'b0;
      else if (i < 90) exp_tx[base+i] = b[(i-10)/10];
      else             exp_tx[base+i] = 1'b1;
      exp_busy[base+i] = 1'b1;
    end
    exp_done[base+99] = 1'b1;
  endtask

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 1024; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] decode(input int base);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = obs_tx[base + 10*(j+1) + 5];
    return r;
  endfunction

  task automatic test_reset();
    int d;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    reset_n = 1'b1;
    clear_expect();
    capture(200);
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL idle_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    d = first_diff(obs_busy, exp_busy);
    checks++; if (d >= 0) begin errors++; $display("FAIL idle_busy: cycle %0d got %b expected %b", d, obs_busy[d], exp_busy[d]); end
    $display("test_reset: done, %0d errors so far", errors);
  endtask

  task automatic test_single_frame();
    int d;
    clear_expect();
    add_frame(8'hA5, 1);
    fork
      capture(110);
      begin
        data_in = 8'hA5; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
      end
    join
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL single_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    d = first_diff(obs_busy, exp_busy);
    checks++; if (d >= 0) begin errors++; $display("FAIL single_busy: cycle %0d got %b expected %b", d, obs_busy[d], exp_busy[d]); end
    d = first_diff(obs_done, exp_done);
    checks++; if (d >= 0) begin errors++; $display("FAIL single_tx_done: cycle %0d got %b expected %b", d, obs_done[d], exp_done[d]); end
    checks++; if (decode(1) !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h expected a5", decode(1)); end
    $display("test_single_frame: byte a5 decoded as %h", decode(1));
  endtask

  task automatic test_back_to_back();
    int d;
    clear_expect();
    add_frame(8'h55, 1);
    add_frame(8'h0F, 101);
    fork
      capture(215);
      begin
        data_in = 8'h55; send = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h0F;
        @(posedge clk); #1;
        send = 1'b0;
      end
    join
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    d = first_diff(obs_busy, exp_busy);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_busy: cycle %0d got %b expected %b", d, obs_busy[d], exp_busy[d]); end
    checks++; if ($countones(obs_done) != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", $countones(obs_done)); end
    checks++; if (decode(1) !== 8'h55) begin errors++; $display("FAIL b2b_byte0: got %h expected 55", decode(1)); end
    checks++; if (decode(101) !== 8'h0F) begin errors++; $display("FAIL b2b_byte1: got %h expected 0f", decode(101)); end
    $display("test_back_to_back: decoded %h %h", decode(1), decode(101));
  endtask

  task automatic test_fifo_full();
    int d;
    clear_expect();
    for (int k = 0; k < 5; k++) add_frame(8'(k + 1), 1 + 100*k);
    fork
      capture(510);
      begin
        send = 1'b1;
        for (int k = 1; k <= 6; k++) begin
          data_in = 8'(k);
          @(posedge clk); #1;
          if (k == 5) begin
            checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ready); end
          end
        end
        send = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_drop_count: got %0d expected 4", fifo_count); end
      end
    join
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL full_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    d = first_diff(obs_busy, exp_busy);
    checks++; if (d >= 0) begin errors++; $display("FAIL full_busy: cycle %0d got %b expected %b", d, obs_busy[d], exp_busy[d]); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (decode(1 + 100*k) !== 8'(k + 1)) begin
        errors++; $display("FAIL full_byte%0d: got %h expected %h", k, decode(1 + 100*k), 8'(k + 1));
      end
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d expected 0", fifo_count); end
    $display("test_fifo_full: five frames captured, byte 06 expected dropped");
  endtask

  task automatic test_reset_mid_frame();
    int d;
    data_in = 8'hFF; send = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h11;
    @(posedge clk); #1;
    data_in = 8'h22;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (43) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_count_before: got %0d expected 2", fifo_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL mid_tx_done: got %b expected 0", tx_done); end
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    clear_expect();
    capture(30);
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_after_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    checks++; if ($countones(obs_done) != 0) begin errors++; $display("FAIL mid_after_done: got %0d pulses expected 0", $countones(obs_done)); end
    clear_expect();
    add_frame(8'h00, 1);
    fork
      capture(110);
      begin
        data_in = 8'h00; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
      end
    join
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_clean_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    d = first_diff(obs_done, exp_done);
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_clean_done: cycle %0d got %b expected %b", d, obs_done[d], exp_done[d]); end
    $display("test_reset_mid_frame: post-reset byte decoded as %h", decode(1));
  endtask

  task automatic test_write_during_pop();
    int d;
    clear_expect();
    add_frame(8'h3C, 1);
    add_frame(8'hC3, 101);
    add_frame(8'h5A, 201);
    add_frame(8'h96, 301);
    fork
      capture(410);
      begin
        data_in = 8'h3C; send = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hC3;
        @(posedge clk); #1;
        data_in = 8'h5A;
        @(posedge clk); #1;
        send = 1'b0;
        repeat (98) begin @(posedge clk); #1; end
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pop_count_before: got %0d expected 2", fifo_count); end
        data_in = 8'h96; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pop_count_after: got %0d expected 2", fifo_count); end
      end
    join
    d = first_diff(obs_tx, exp_tx);
    checks++; if (d >= 0) begin errors++; $display("FAIL pop_tx: cycle %0d got %b expected %b", d, obs_tx[d], exp_tx[d]); end
    checks++; if (decode(301) !== 8'h96) begin errors++; $display("FAIL pop_last_byte: got %h expected 96", decode(301)); end
    $display("test_write_during_pop: decoded %h %h %h %h", decode(1), decode(101), decode(201), decode(301));
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_write_during_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
